// File: rtl/acc_ctx_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : acc_ctx_reg_file
// Description : Accumulator-style register file with a shadow bank for
//               multi-cycle context save / restore.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_ctx_reg_file #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          regWrite,
    input  logic          regSet,
    input  logic          regGet,
    input  logic          lutLoad,
    input  logic          regClear,
    input  logic          ctxSave,
    input  logic          ctxRestore,
    input  logic [DW-1:0] writeData,
    input  logic [DW-1:0] LUTaddr,
    input  logic [PW-1:0] opRegAddr,
    output logic [DW-1:0] accData,
    output logic [DW-1:0] opRegData,
    output logic          busy,
    output logic          ctxValid
);

    localparam int            c_NREG = 2 ** PW;
    localparam logic [PW-1:0] c_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_regs   [c_NREG];
    logic [DW-1:0] r_shadow [c_NREG];
    logic [PW-1:0] r_index;
    logic          r_ctx_valid;

    logic w_do_write;
    logic w_do_set;
    logic w_do_get;
    logic w_do_lut;
    logic w_do_save;
    logic w_do_restore;
    logic w_do_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One command per idle cycle; ctxRestore claims its priority slot even
    // when no saved context exists, so it still masks regClear.
    always_comb begin
        w_state_next = r_state;
        w_do_write   = 1'b0;
        w_do_set     = 1'b0;
        w_do_get     = 1'b0;
        w_do_lut     = 1'b0;
        w_do_save    = 1'b0;
        w_do_restore = 1'b0;
        w_do_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (regWrite) begin
                    w_do_write = 1'b1;
                end else if (regSet) begin
                    w_do_set = 1'b1;
                end else if (regGet) begin
                    w_do_get = 1'b1;
                end else if (lutLoad) begin
                    w_do_lut = 1'b1;
                end else if (ctxSave) begin
                    w_do_save    = 1'b1;
                    w_state_next = ST_SAVE;
                end else if (ctxRestore) begin
                    if (r_ctx_valid) begin
                        w_do_restore = 1'b1;
                        w_state_next = ST_RESTORE;
                    end
                end else if (regClear) begin
                    w_do_clear = 1'b1;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (r_index == c_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_index     <= '0;
            r_ctx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_do_write) begin
                        r_regs[0] <= writeData;
                    end
                    if (w_do_set) begin
                        r_regs[opRegAddr] <= r_regs[0];
                    end
                    if (w_do_get) begin
                        r_regs[0] <= r_regs[opRegAddr];
                    end
                    if (w_do_lut) begin
                        r_regs[0] <= LUTaddr;
                    end
                    if (w_do_clear) begin
                        for (int i = 0; i < c_NREG; i++) begin
                            r_regs[i] <= '0;
                        end
                    end
                    if (w_do_save) begin
                        r_index     <= '0;
                        r_ctx_valid <= 1'b0;
                    end
                    if (w_do_restore) begin
                        r_index <= '0;
                    end
                end
                ST_SAVE: begin
                    r_shadow[r_index] <= r_regs[r_index];
                    r_index           <= r_index + 1'b1;
                    if (r_index == c_LAST) begin
                        r_ctx_valid <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    r_regs[r_index] <= r_shadow[r_index];
                    r_index         <= r_index + 1'b1;
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

    assign accData   = r_regs[0];
    assign opRegData = r_regs[opRegAddr];
    assign busy      = (r_state == ST_SAVE) || (r_state == ST_RESTORE);
    assign ctxValid  = r_ctx_valid;

endmodule
`default_nettype wire

// File: tb/tb_acc_ctx_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_ctx_reg_file
// Description : Scoreboard bench for acc_ctx_reg_file with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_ctx_reg_file;

    localparam logic [6:0] c_W  = 7'b1000000;
    localparam logic [6:0] c_S  = 7'b0100000;
    localparam logic [6:0] c_G  = 7'b0010000;
    localparam logic [6:0] c_L  = 7'b0001000;
    localparam logic [6:0] c_SV = 7'b0000100;
    localparam logic [6:0] c_RS = 7'b0000010;
    localparam logic [6:0] c_CL = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       regWrite = 1'b0, regSet = 1'b0, regGet = 1'b0, lutLoad = 1'b0;
    logic       regClear = 1'b0, ctxSave = 1'b0, ctxRestore = 1'b0;
    logic [7:0] writeData = '0, LUTaddr = '0;
    logic [3:0] opRegAddr = '0;
    logic [7:0] accData, opRegData;
    logic       busy, ctxValid;

    acc_ctx_reg_file #(.DW(8), .PW(4)) dut (
        .clk(clk), .reset(reset),
        .regWrite(regWrite), .regSet(regSet), .regGet(regGet),
        .lutLoad(lutLoad), .regClear(regClear),
        .ctxSave(ctxSave), .ctxRestore(ctxRestore),
        .writeData(writeData), .LUTaddr(LUTaddr), .opRegAddr(opRegAddr),
        .accData(accData), .opRegData(opRegData),
        .busy(busy), .ctxValid(ctxValid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] op;
        logic       bsy;
        logic       vld;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  chk_strobe = 1'b0;

    // Reference model: plain arrays plus a countdown of remaining busy cycles.
    logic [7:0] m_r  [16];
    logic [7:0] m_sh [16];
    int         m_left = 0;
    bit         m_rest = 1'b0;
    bit         m_valid = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_r[i]  = '0;
            m_sh[i] = '0;
        end
        m_left  = 0;
        m_rest  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_clock(input logic [6:0] c, input logic [7:0] wd,
                               input logic [7:0] la, input logic [3:0] a);
        if (m_left > 0) begin
            if (m_rest) m_r[16 - m_left] = m_sh[16 - m_left];
            m_left--;
            if (m_left == 0 && !m_rest) m_valid = 1'b1;
        end else if (c[6]) begin
            m_r[0] = wd;
        end else if (c[5]) begin
            m_r[a] = m_r[0];
        end else if (c[4]) begin
            m_r[0] = m_r[a];
        end else if (c[3]) begin
            m_r[0] = la;
        end else if (c[2]) begin
            for (int i = 0; i < 16; i++) m_sh[i] = m_r[i];
            m_valid = 1'b0;
            m_rest  = 1'b0;
            m_left  = 16;
        end else if (c[1]) begin
            if (m_valid) begin
                m_rest = 1'b1;
                m_left = 16;
            end
        end else if (c[0]) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
        end
    endtask

    function automatic exp_t model_out(input logic [3:0] a);
        exp_t e;
        e.acc = m_r[0];
        e.op  = m_r[a];
        e.bsy = (m_left > 0);
        e.vld = m_valid;
        return e;
    endfunction

    task automatic step(input logic [6:0] c, input logic [7:0] wd,
                        input logic [7:0] la, input logic [3:0] a,
                        input string nm);
        @(negedge clk);
        {regWrite, regSet, regGet, lutLoad, ctxSave, ctxRestore, regClear} = c;
        writeData = wd;
        LUTaddr   = la;
        opRegAddr = a;
        model_clock(c, wd, la, a);
        exp_q.push_back(model_out(a));
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    // Asserts reset mid-cycle and checks the outputs before the next edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        {regWrite, regSet, regGet, lutLoad, ctxSave, ctxRestore, regClear} = '0;
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(model_out(opRegAddr));
        name_q.push_back(nm);
        chk_strobe = ~chk_strobe;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 16; i++) step('0, '0, '0, i[3:0], nm);
    endtask

    // Monitor: outputs are always presented, sampled 1 time unit after each
    // clock edge or an asynchronous check request.
    always begin
        exp_t  e;
        string nm;
        @(posedge clk or chk_strobe);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (accData !== e.acc || opRegData !== e.op ||
                busy !== e.bsy || ctxValid !== e.vld) begin
                n_fail++;
                $display("FAIL %s @%0t: got acc=%h op=%h busy=%b valid=%b, expected acc=%h op=%h busy=%b valid=%b (addr=%0d)",
                         nm, $time, accData, opRegData, busy, ctxValid,
                         e.acc, e.op, e.bsy, e.vld, opRegAddr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] c;
        model_reset();
        #2;
        exp_q.push_back(model_out(opRegAddr));
        name_q.push_back("reset_state");
        chk_strobe = ~chk_strobe;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        step(c_RS, '0, '0, 4'd3, "invalid_restore");
        step('0, '0, '0, 4'd0, "invalid_restore_idle");

        step(c_W, 8'h5A, '0, 4'd0, "prio_write");
        step(c_S, '0, '0, 4'd3, "prio_set");
        step('0, '0, '0, 4'd3, "prio_read_r3");
        step(c_W | c_S, 8'h11, '0, 4'd3, "prio_write_over_set");
        step(c_S, '0, '0, 4'd0, "set_r0_noop");
        step(c_G, '0, '0, 4'd0, "get_r0_noop");

        step(c_W, 8'h3C, '0, 4'd0, "get_prep");
        step(c_S, '0, '0, 4'd9, "get_prep_set");
        step(c_W, 8'h00, '0, 4'd9, "get_prep_zero");
        step(c_G, '0, '0, 4'd9, "regget");
        step(c_L, '0, 8'hA7, 4'd9, "lutload");
        step(c_L | c_SV | c_CL, '0, 8'h42, 4'd9, "lut_over_save");

        for (int i = 15; i >= 0; i--) begin
            step(c_W, 8'h10 + 8'(i), '0, 4'd0, "load_seq");
            step(c_S, '0, '0, i[3:0], "load_set");
        end
        step(c_SV, '0, '0, 4'd0, "save_start");
        step(c_W, 8'hFF, '0, 4'd0, "save_lockout_write");
        for (int i = 0; i < 14; i++) step(c_CL | c_RS, '0, '0, i[3:0], "save_busy");
        step('0, '0, '0, 4'd0, "save_done");
        sweep("after_save");
        step(c_CL, '0, '0, 4'd5, "clear");
        sweep("after_clear");
        step(c_RS, '0, '0, 4'd7, "restore_start");
        for (int i = 0; i < 15; i++) step(c_W | c_SV, 8'hEE, '0, i[3:0], "restore_busy");
        step('0, '0, '0, 4'd7, "restore_r7");
        sweep("after_restore");

        step(c_SV, '0, '0, 4'd2, "save2_start");
        for (int i = 0; i < 5; i++) step('0, '0, '0, 4'd2, "save2_busy");
        async_reset("reset_mid_save");
        step('0, '0, '0, 4'd2, "after_mid_reset");
        step(c_RS, '0, '0, 4'd2, "restore_after_abort");

        for (int n = 0; n < 600; n++) begin
            c = '0;
            for (int b = 0; b < 7; b++) if ($urandom_range(0, 5) == 0) c[b] = 1'b1;
            step(c, 8'($urandom), 8'($urandom), 4'($urandom), "random");
        end

        step('0, '0, '0, 4'd0, "final");
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
